// File: rtl/game_flow_controller.sv
// Game flow sequencer: IDLE -> COUNTDOWN -> PLAY (-> PAUSE) -> GAMEOVER, with a BCD round timer.
// Optional pause support is enabled by defining GAME_FLOW_PAUSE_EN.
module game_flow_controller #(
    parameter int COUNTDOWN_SEC = 3,
    parameter int ROUND_SEC     = 99
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startKey,
    input  logic       pauseKey,
    input  logic       one_sec,
    input  logic       tank1Win,
    input  logic       tank2Win,
    input  logic       tank1Lose,
    input  logic       tank2Lose,
    output logic       countEn,
    output logic       scoreClearN,
    output logic [2:0] state,
    output logic [3:0] countdownDigit,
    output logic [3:0] timerDigit1,
    output logic [3:0] timerDigit2,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        GAMEOVER  = 3'd4
    } state_t;

    localparam logic [3:0] CD_INIT  = 4'(COUNTDOWN_SEC);
    localparam logic [3:0] RT_TENS  = 4'(ROUND_SEC / 10);
    localparam logic [3:0] RT_UNITS = 4'(ROUND_SEC % 10);

    state_t st;
    logic   start_prev;
    logic   start_ev;
    logic   t1_res;
    logic   t2_res;

    assign start_ev = startKey & ~start_prev;
    assign t1_res   = tank1Win | tank2Lose;
    assign t2_res   = tank2Win | tank1Lose;
    assign state    = st;

`ifdef GAME_FLOW_PAUSE_EN
    logic pause_prev;
    logic pause_ev;
    assign pause_ev = pauseKey & ~pause_prev;
`else
    logic unused_pause_key;
    assign unused_pause_key = pauseKey;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st             <= IDLE;
            countEn        <= 1'b0;
            scoreClearN    <= 1'b0;
            winner         <= '0;
            countdownDigit <= CD_INIT;
            timerDigit1    <= RT_TENS;
            timerDigit2    <= RT_UNITS;
            start_prev     <= 1'b1;
`ifdef GAME_FLOW_PAUSE_EN
            pause_prev     <= 1'b1;
`endif
        end else begin
            start_prev  <= startKey;
`ifdef GAME_FLOW_PAUSE_EN
            pause_prev  <= pauseKey;
`endif
            scoreClearN <= 1'b1;
            case (st)
                IDLE, GAMEOVER: begin
                    if (start_ev) begin
                        scoreClearN    <= 1'b0;
                        countdownDigit <= CD_INIT;
                        timerDigit1    <= RT_TENS;
                        timerDigit2    <= RT_UNITS;
                        winner         <= '0;
                        st             <= COUNTDOWN;
                    end
                end
                COUNTDOWN: begin
                    if (one_sec) begin
                        if (countdownDigit == 4'd1) begin
                            countdownDigit <= '0;
                            countEn        <= 1'b1;
                            st             <= PLAY;
                        end else begin
                            countdownDigit <= countdownDigit - 4'd1;
                        end
                    end
                end
                PLAY: begin
                    // {t2,t1} encodes 1=tank1, 2=tank2, 3=both flagged (draw)
                    if (t1_res | t2_res) begin
                        winner  <= {t2_res, t1_res};
                        countEn <= 1'b0;
                        st      <= GAMEOVER;
                    end
`ifdef GAME_FLOW_PAUSE_EN
                    else if (pause_ev) begin
                        countEn <= 1'b0;
                        st      <= PAUSE;
                    end
`endif
                    else if (one_sec) begin
                        if (timerDigit1 == 4'd0 && timerDigit2 == 4'd0) begin
                            winner  <= 2'd3;
                            countEn <= 1'b0;
                            st      <= GAMEOVER;
                        end else if (timerDigit2 == 4'd0) begin
                            timerDigit2 <= 4'd9;
                            timerDigit1 <= timerDigit1 - 4'd1;
                        end else begin
                            timerDigit2 <= timerDigit2 - 4'd1;
                        end
                    end
                end
`ifdef GAME_FLOW_PAUSE_EN
                PAUSE: begin
                    if (pause_ev) begin
                        countEn <= 1'b1;
                        st      <= PLAY;
                    end
                end
`endif
                default: begin
                    countEn <= 1'b0;
                    st      <= IDLE;
                end
            endcase
        end
    end

endmodule
